// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared types and constants for the registered control decoder
//
// Purpose: opcode and state enumerations, base ALUOp codes, and the control
//          bundle struct shared by ctrl_decode_comb and ctrl_decode_pipe.
// Ports:   none (package).

package ctrl_pkg;

  typedef enum logic [2:0] {
    OP_ADD    = 3'b000,
    OP_XOR    = 3'b001,
    OP_AND    = 3'b010,
    OP_MEM    = 3'b011,
    OP_ADDI   = 3'b100,
    OP_SHIFT  = 3'b101,
    OP_BRANCH = 3'b110,
    OP_PARITY = 3'b111
  } opcode_e;

  // Base ALUOp codes; zero-extended to the configured ALUOp width.
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_XOR = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_SRA = 3'd3;
  localparam logic [2:0] ALU_SRL = 3'd4;
  localparam logic [2:0] ALU_SLL = 3'd5;
  localparam logic [2:0] ALU_ROR = 3'd6;
  localparam logic [2:0] ALU_ROL = 3'd7;

  // ALUOp is carried alongside this struct because its width is a
  // parameter of the instantiating module.
  typedef struct packed {
    logic       truncated_reg;
    logic       trunc_prefix;
    logic       abs_branch;
    logic       rel_branch;
    logic       branch_invert;
    logic       branch_flag;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       parity_op;
    logic [1:0] second_operand;
  } ctrl_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    PAR   = 2'd2
  } state_e;

  // Starting point of every decode: register write on, register operand.
  function automatic ctrl_t ctrl_default();
    ctrl_t c;
    c                = '0;
    c.reg_write      = 1'b1;
    c.second_operand = 2'b01;
    return c;
  endfunction

endpackage

// File: rtl/ctrl_decode_comb.sv
// rtl/ctrl_decode_comb.sv - combinational instruction to control bundle decode
//
// Purpose: maps one instruction onto the control bundle, ALUOp and the
//          illegal-encoding flag. No state.
// Ports:   instr   in  IW   instruction (opcode = top 3 bits, mode = [3:0])
//          ctrl    out      decoded flags and second-operand select
//          alu_op  out OPW  decoded ALU operation
//          illegal out 1    undefined shift mode

module ctrl_decode_comb
  import ctrl_pkg::*;
#(
  parameter int IW  = 9,
  parameter int OPW = 5
) (
  input  logic [IW-1:0]  instr,
  output ctrl_t          ctrl,
  output logic [OPW-1:0] alu_op,
  output logic           illegal
);

  opcode_e    opcode;
  logic [3:0] mode;
  logic       unused_mid_bits;

  assign opcode          = opcode_e'(instr[IW-1:IW-3]);
  assign mode            = instr[3:0];
  assign unused_mid_bits = ^instr[IW-4:4];

  always_comb begin
    ctrl    = ctrl_default();
    alu_op  = '0;
    illegal = 1'b0;
    case (opcode)
      OP_ADD: alu_op = OPW'(ALU_ADD);
      OP_XOR: alu_op = OPW'(ALU_XOR);
      OP_AND: alu_op = OPW'(ALU_AND);
      OP_MEM: begin
        alu_op              = OPW'(ALU_XOR);
        ctrl.truncated_reg  = 1'b1;
        ctrl.second_operand = 2'b00;
        if (mode[3]) begin
          ctrl.mem_write = 1'b1;
          ctrl.reg_write = 1'b0;
        end else begin
          ctrl.mem_to_reg = 1'b1;
        end
      end
      OP_ADDI: begin
        alu_op              = OPW'(ALU_ADD);
        ctrl.truncated_reg  = 1'b1;
        ctrl.trunc_prefix   = 1'b1;
        ctrl.second_operand = 2'b10;
      end
      OP_SHIFT: begin
        case (mode[2:0])
          3'b000:  alu_op = OPW'(ALU_SRL);
          3'b010:  alu_op = OPW'(ALU_SLL);
          3'b011:  alu_op = OPW'(ALU_SRA);
          3'b100:  alu_op = OPW'(ALU_ROR);
          3'b110:  alu_op = OPW'(ALU_ROL);
          default: begin
            illegal        = 1'b1;
            ctrl.reg_write = 1'b0;
          end
        endcase
      end
      OP_BRANCH: begin
        ctrl.reg_write     = 1'b0;
        ctrl.abs_branch    = mode[0];
        ctrl.rel_branch    = ~mode[0];
        ctrl.branch_flag   = mode[1];
        ctrl.branch_invert = mode[2];
      end
      OP_PARITY: begin
        // Parity ALUOp: top bit set, mode in the low nibble, zeros between.
        ctrl.parity_op  = 1'b1;
        alu_op[3:0]     = mode;
        alu_op[OPW-1]   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ctrl_decode_pipe.sv
// rtl/ctrl_decode_pipe.sv - registered, handshaked control decoder with parity sequencing
//
// Purpose: decodes one instruction per cycle into a registered control bundle;
//          parity instructions are replayed as PAR_STEPS micro-ops; flush drops
//          the held/in-progress op.
// Ports:   Clk, Reset (async, active-high)
//          in_valid/in_ready/instr      upstream handshake and instruction
//          flush                        discard held op (taken branch)
//          out_valid/out_ready          downstream handshake
//          TruncatedReg..ParityOp, SecondOperand, ALUOp  registered bundle
//          ParityStep, ParityLast       micro-op index / final micro-op
//          Illegal                      undefined encoding

module ctrl_decode_pipe
  import ctrl_pkg::*;
#(
  parameter int IW        = 9,
  parameter int OPW       = 5,
  parameter int PAR_STEPS = 2
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [IW-1:0]                instr,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         TruncatedReg,
  output logic                         TruncPrefix,
  output logic                         AbsBranch,
  output logic                         RelBranch,
  output logic                         BranchInvert,
  output logic                         BranchFlag,
  output logic                         MemWrite,
  output logic                         RegWrite,
  output logic                         MemToReg,
  output logic                         ParityOp,
  output logic [1:0]                   SecondOperand,
  output logic [OPW-1:0]               ALUOp,
  output logic [$clog2(PAR_STEPS):0]   ParityStep,
  output logic                         ParityLast,
  output logic                         Illegal
);

  localparam int              SW        = $clog2(PAR_STEPS) + 1;
  localparam logic [SW-1:0]   LAST_STEP = SW'(PAR_STEPS - 1);

  ctrl_t          dec_ctrl;
  logic [OPW-1:0] dec_alu;
  logic           dec_illegal;

  state_e         state_q, state_d;
  ctrl_t          ctrl_q;
  logic [OPW-1:0] alu_q;
  logic           illegal_q;
  logic [SW-1:0]  step_q, step_d;
  logic           last_q, last_d;
  logic           load;
  logic           accept;
  logic           handshake;

  ctrl_decode_comb #(
    .IW  (IW),
    .OPW (OPW)
  ) u_decode (
    .instr   (instr),
    .ctrl    (dec_ctrl),
    .alu_op  (dec_alu),
    .illegal (dec_illegal)
  );

  assign out_valid = (state_q != EMPTY);
  assign handshake = out_valid & out_ready;
  assign accept    = in_valid & in_ready;

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      EMPTY:   in_ready = ~flush;
      FULL:    in_ready = out_ready & ~flush;
      default: in_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    last_d  = last_q;
    load    = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: load = accept;
        FULL: begin
          if (handshake) begin
            if (accept) load = 1'b1;
            else        state_d = EMPTY;
          end
        end
        PAR: begin
          if (handshake) begin
            step_d = step_q + 1'b1;
            if (step_d == LAST_STEP) begin
              last_d  = 1'b1;
              state_d = FULL;
            end
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    // A newly accepted instruction always restarts the micro-op index; a
    // single-step parity op skips PAR and is final immediately.
    if (load) begin
      step_d = '0;
      if (dec_ctrl.parity_op && (PAR_STEPS > 1)) begin
        state_d = PAR;
        last_d  = 1'b0;
      end else begin
        state_d = FULL;
        last_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= EMPTY;
      ctrl_q    <= '0;
      alu_q     <= '0;
      illegal_q <= 1'b0;
      step_q    <= '0;
      last_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      last_q  <= last_d;
      if (load) begin
        ctrl_q    <= dec_ctrl;
        alu_q     <= dec_alu;
        illegal_q <= dec_illegal;
      end
    end
  end

  assign TruncatedReg  = ctrl_q.truncated_reg;
  assign TruncPrefix   = ctrl_q.trunc_prefix;
  assign AbsBranch     = ctrl_q.abs_branch;
  assign RelBranch     = ctrl_q.rel_branch;
  assign BranchInvert  = ctrl_q.branch_invert;
  assign BranchFlag    = ctrl_q.branch_flag;
  assign MemWrite      = ctrl_q.mem_write;
  assign RegWrite      = ctrl_q.reg_write;
  assign MemToReg      = ctrl_q.mem_to_reg;
  assign ParityOp      = ctrl_q.parity_op;
  assign SecondOperand = ctrl_q.second_operand;
  assign ALUOp         = alu_q;
  assign ParityStep    = step_q;
  assign ParityLast    = last_q;
  assign Illegal       = illegal_q;

endmodule
